// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M-style integer multiplier: one op per cycle, fixed LATENCY, tagged results.
// The product is formed at acceptance; the remaining stages only carry valid/tag/result forward.
module fu_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 7,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic [WIDTH-1:0] res,
  output logic [TAG_W-1:0] tag_out,
  output logic             finish,
  output logic             busy
);

  logic                 accept_s;
  logic [WIDTH:0]       a_ext_s;
  logic [WIDTH:0]       b_ext_s;
  logic [2*WIDTH-1:0]   a_wide_s;
  logic [2*WIDTH-1:0]   b_wide_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     result_s;
  logic [LATENCY-1:0]   valid_r;
  logic [TAG_W-1:0]     tag_r  [LATENCY];
  logic [WIDTH-1:0]     data_r [LATENCY];

  // Flush dominates issue; an X on EN cannot leak into the valid chain while flush is high.
  assign accept_s = EN & ~flush;

  // Operand extension per mode and product formation; only the low 2*WIDTH product bits are ever used.
  always_comb begin
    a_ext_s = {1'b0, A};
    b_ext_s = {1'b0, B};
    case (op)
      2'b01: begin
        a_ext_s = {A[WIDTH-1], A};
        b_ext_s = {B[WIDTH-1], B};
      end
      2'b10: begin
        a_ext_s = {A[WIDTH-1], A};
        b_ext_s = {1'b0, B};
      end
      default: begin
        a_ext_s = {1'b0, A};
        b_ext_s = {1'b0, B};
      end
    endcase
    a_wide_s = {{(WIDTH-1){a_ext_s[WIDTH]}}, a_ext_s};
    b_wide_s = {{(WIDTH-1){b_ext_s[WIDTH]}}, b_ext_s};
    prod_s   = a_wide_s * b_wide_s;
    if (op == 2'b00) begin
      result_s = prod_s[WIDTH-1:0];
    end else begin
      result_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Stage chain: data moves only with a surviving valid op, so the last stage holds the last completed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= accept_s;
      if (accept_s) begin
        data_r[0] <= result_s;
        tag_r[0]  <= tag_in;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1] & ~flush;
        if (valid_r[i-1] && !flush) begin
          data_r[i] <= data_r[i-1];
          tag_r[i]  <= tag_r[i-1];
        end
      end
    end
  end

  assign res     = data_r[LATENCY-1];
  assign tag_out = tag_r[LATENCY-1];
  assign finish  = valid_r[LATENCY-1];
  assign busy    = |valid_r;

endmodule
